// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// State codes, opcode/funct values and datapath select encodings.
package mc_ctrl_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int          STW      = 3;

  typedef enum logic [STW-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_JR   = 6'h08;

  localparam logic [2:0] ALU_ADDU = 3'd0;
  localparam logic [2:0] ALU_SUBU = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DR  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  typedef struct packed {
    logic r_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } cls_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Opcode/funct to instruction-class decode for mc_ctrl.
// Exactly one class bit is set for any input.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  logic rt;
  assign rt = (opcode == OP_RTYPE);

  always_comb begin
    cls = '0;
    unique case (1'b1)
      rt && (funct == F_ADDU): cls.r_alu = 1'b1;
      rt && (funct == F_SUBU): cls.r_alu = 1'b1;
      rt && (funct == F_JR):   cls.jr    = 1'b1;
      opcode == OP_ORI:        cls.ori   = 1'b1;
      opcode == OP_LUI:        cls.lui   = 1'b1;
      opcode == OP_LW:         cls.lw    = 1'b1;
      opcode == OP_SW:         cls.sw    = 1'b1;
      opcode == OP_BEQ:        cls.beq   = 1'b1;
      opcode == OP_J:          cls.j     = 1'b1;
      opcode == OP_JAL:        cls.jal   = 1'b1;
      default:                 cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM driving the shared datapath.
// Define MC_CTRL_INSTR_CNT_EN to build the retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RFWr,
  output logic        DMWr,
  output logic        SignOp,
  output logic [2:0]  ALUOp,
  output logic        ALUSrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic [1:0]  NPCOp,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  state_t st, nxt;
  cls_t   c;

  mc_ctrl_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (c)
  );

  assign state = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_FETCH;
    else       st <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (c.r_alu | c.ori | c.lui | c.lw | c.sw)
          nxt = S_EXE;
        else if (c.beq)
          nxt = S_BRANCH;
        else if (c.j | c.jal | c.jr)
          nxt = S_JUMP;
      end
      S_EXE:    nxt = (c.lw | c.sw) ? S_MEM : S_WB;
      S_MEM:    nxt = c.lw ? S_WB : S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  // Everything gated by reset so an aborted instruction writes nothing.
  always_comb begin
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    SignOp  = 1'b0;
    ALUOp   = ALU_ADDU;
    ALUSrc  = 1'b0;
    RegDst  = RD_RT;
    WDSel   = WD_ALU;
    NPCOp   = NPC_PC4;
    illegal = 1'b0;
    if (!reset) begin
      case (st)
        S_FETCH: begin
          IRWr  = 1'b1;
          PCWr  = 1'b1;
        end
        S_DECODE: illegal = c.illegal;
        S_EXE: begin
          unique case (1'b1)
            c.r_alu: ALUOp = (funct == F_SUBU) ? ALU_SUBU : ALU_ADDU;
            c.ori: begin
              ALUOp  = ALU_OR;
              ALUSrc = 1'b1;
            end
            c.lui: begin
              ALUOp  = ALU_LUI;
              ALUSrc = 1'b1;
            end
            c.lw || c.sw: begin
              ALUSrc = 1'b1;
              SignOp = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: DMWr = c.sw;
        S_WB: begin
          RFWr = 1'b1;
          if (c.r_alu) RegDst = RD_RD;
          if (c.lw)    WDSel  = WD_DR;
        end
        S_BRANCH: begin
          ALUOp  = ALU_SUBU;
          SignOp = 1'b1;
          NPCOp  = NPC_BR;
          PCWr   = zero;
        end
        S_JUMP: begin
          PCWr  = 1'b1;
          NPCOp = c.jr ? NPC_JR : NPC_J;
          if (c.jal) begin
            RFWr   = 1'b1;
            RegDst = RD_RA;
            WDSel  = WD_PC;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_INSTR_CNT_EN
  logic        retire;
  logic [31:0] cnt;

  assign retire = (st == S_WB) || (st == S_BRANCH) ||
                  (st == S_JUMP) || ((st == S_MEM) && c.sw);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (retire) cnt <= cnt + 32'd1;
  end

  assign instr_cnt = cnt;
`else
  assign instr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl.
// Counter expectations follow MC_CTRL_INSTR_CNT_EN.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        PCWr, IRWr, RFWr, DMWr, SignOp, ALUSrc, illegal;
  logic [2:0]  ALUOp, state;
  logic [1:0]  RegDst, WDSel, NPCOp;
  logic [31:0] instr_cnt;
  logic [18:0] obs;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_cnt = 32'h0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .RFWr      (RFWr),
    .DMWr      (DMWr),
    .SignOp    (SignOp),
    .ALUOp     (ALUOp),
    .ALUSrc    (ALUSrc),
    .RegDst    (RegDst),
    .WDSel     (WDSel),
    .NPCOp     (NPCOp),
    .state     (state),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  assign obs = {state, PCWr, IRWr, RFWr, DMWr, SignOp, ALUOp,
                ALUSrc, RegDst, WDSel, NPCOp, illegal};

  // Expected output bundle, fields in the same order as obs.
  function automatic logic [18:0] ev(
    input int s, input int pc, input int ir, input int rf,
    input int dm, input int so, input int aop, input int asrc,
    input int rd, input int wd, input int npc, input int ill);
    return {s[2:0], pc[0], ir[0], rf[0], dm[0], so[0], aop[2:0],
            asrc[0], rd[1:0], wd[1:0], npc[1:0], ill[0]};
  endfunction

  function automatic void bump();
`ifdef MC_CTRL_INSTR_CNT_EN
    exp_cnt = exp_cnt + 32'd1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [18:0] F, D;
  initial begin
    F = ev(0,1,1,0,0,0,0,0,0,0,0,0);
    D = ev(1,0,0,0,0,0,0,0,0,0,0,0);
  end

  task automatic test_reset();
    reset = 1'b1; opcode = 6'h0d; funct = 6'h00; zero = 1'b0;
    #1;
    tests++;
    if (obs !== 19'h0) begin
      fails++;
      $display("FAIL reset_outs got %h want %h", obs, 19'h0);
    end
    tests++;
    if (instr_cnt !== 32'h0) begin
      fails++;
      $display("FAIL reset_cnt got %h want 0", instr_cnt);
    end
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_ori();
    logic [18:0] e [4];
    e[0] = F; e[1] = D;
    e[2] = ev(2,0,0,0,0,0,2,1,0,0,0,0);
    e[3] = ev(4,0,0,1,0,0,0,0,0,0,0,0);
    opcode = 6'h0d; funct = 6'h00;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL ori c%0d got %h want %h", i, obs, e[i]);
      end
      step();
    end
    bump();
    tests++;
    if (instr_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL ori_cnt got %0d want %0d", instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_rtype();
    logic [18:0] e [4];
    e[0] = F; e[1] = D;
    e[2] = ev(2,0,0,0,0,0,1,0,0,0,0,0);
    e[3] = ev(4,0,0,1,0,0,0,0,1,0,0,0);
    opcode = 6'h00; funct = 6'h23;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL subu c%0d got %h want %h", i, obs, e[i]);
      end
      step();
    end
    bump();
  endtask

  task automatic test_lw_sw();
    logic [18:0] l [5];
    logic [18:0] s [4];
    l[0] = F; l[1] = D;
    l[2] = ev(2,0,0,0,0,1,0,1,0,0,0,0);
    l[3] = ev(3,0,0,0,0,0,0,0,0,0,0,0);
    l[4] = ev(4,0,0,1,0,0,0,0,0,1,0,0);
    s[0] = F; s[1] = D; s[2] = l[2];
    s[3] = ev(3,0,0,0,1,0,0,0,0,0,0,0);
    opcode = 6'h23; funct = 6'h00;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (obs !== l[i]) begin
        fails++;
        $display("FAIL lw c%0d got %h want %h", i, obs, l[i]);
      end
      step();
    end
    bump();
    opcode = 6'h2b;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (obs !== s[i]) begin
        fails++;
        $display("FAIL sw c%0d got %h want %h", i, obs, s[i]);
      end
      step();
    end
    bump();
    tests++;
    if (instr_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL lwsw_cnt got %0d want %0d", instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_beq();
    logic [18:0] e [3];
    e[0] = F; e[1] = D;
    opcode = 6'h04; funct = 6'h00;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      e[2] = ev(5,z,0,0,0,1,1,0,0,0,1,0);
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (obs !== e[i]) begin
          fails++;
          $display("FAIL beq z%0d c%0d got %h want %h",
                   z, i, obs, e[i]);
        end
        step();
      end
      bump();
    end
    zero = 1'b0;
    tests++;
    if (instr_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL beq_cnt got %0d want %0d", instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_jal_jr();
    logic [18:0] e [3];
    e[0] = F; e[1] = D;
    opcode = 6'h03; funct = 6'h00;
    e[2] = ev(6,1,0,1,0,0,0,0,2,2,2,0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL jal c%0d got %h want %h", i, obs, e[i]);
      end
      step();
    end
    bump();
    opcode = 6'h00; funct = 6'h08;
    e[2] = ev(6,1,0,0,0,0,0,0,0,0,3,0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL jr c%0d got %h want %h", i, obs, e[i]);
      end
      step();
    end
    bump();
  endtask

  task automatic test_illegal();
    logic [18:0] e [3];
    e[0] = F;
    e[1] = ev(1,0,0,0,0,0,0,0,0,0,0,1);
    e[2] = F;
    opcode = 6'h3f; funct = 6'h00;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (obs !== e[i]) begin
        fails++;
        $display("FAIL illegal c%0d got %h want %h", i, obs, e[i]);
      end
      if (i < 2) step();
    end
    tests++;
    if (instr_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL ill_cnt got %0d want %0d", instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'h0d; funct = 6'h00;
    step();
    step();
    tests++;
    if (state !== 3'd2) begin
      fails++;
      $display("FAIL rst_pre got %0d want 2", state);
    end
    reset = 1'b1;
    #1;
    exp_cnt = 32'h0;
    tests++;
    if (obs !== 19'h0) begin
      fails++;
      $display("FAIL rst_mid got %h want %h", obs, 19'h0);
    end
    tests++;
    if (instr_cnt !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_cnt got %h want 0", instr_cnt);
    end
    step();
    reset = 1'b0;
    #1;
    tests++;
    if (obs !== F) begin
      fails++;
      $display("FAIL rst_after got %h want %h", obs, F);
    end
  endtask

  initial begin
    test_reset();
    test_ori();
    test_rtype();
    test_lw_sw();
    test_beq();
    test_jal_jr();
    test_illegal();
    test_reset_mid();
    test_ori();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
